// File: rtl/serial_frame_receiver_pkg.sv
// Shared types and constants for the serial frame receiver.
// State encoding, line idle level and a counter-width helper.
package serial_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam logic LINE_IDLE = 1'b1;

    // A 1-bit frame still needs a 1-bit counter, so never return a zero width.
    function automatic int cnt_width(input int w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

endpackage

// File: rtl/serial_frame_receiver_if.sv
// Serial line in, recovered parallel word and status pulses out.
interface serial_frame_receiver_if #(
    parameter int DATA_W = 8
);

    logic              sIn;
    logic              bitEn;
    logic [DATA_W-1:0] pOut;
    logic              valid;
    logic              parityErr;
    logic              frameErr;
    logic              busy;

    modport master (
        output sIn, bitEn,
        input  pOut, valid, parityErr, frameErr, busy
    );

    modport slave (
        input  sIn, bitEn,
        output pOut, valid, parityErr, frameErr, busy
    );

endinterface

// File: rtl/serial_frame_receiver_frame_bit_counter.sv
// Data-bit position counter; advances only on qualified bit edges.
module frame_bit_counter
    import serial_pkg::*;
#(
    parameter int DATA_W = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          bit_en,
    input  logic                          clr,
    input  logic                          inc,
    output logic [cnt_width(DATA_W)-1:0]  count,
    output logic                          last
);

    localparam int CNT_W = cnt_width(DATA_W);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (bit_en) begin
            if (clr) begin
                count <= '0;
            end else if (inc) begin
                count <= count + 1'b1;
            end
        end
    end

    assign last = (count == CNT_W'(DATA_W - 1));

endmodule

// File: rtl/serial_frame_receiver.sv
// Recovers start/data/parity/stop framed words from a bitEn-qualified serial line.
module serial_frame_receiver
    import serial_pkg::*;
#(
    parameter int DATA_W    = 8,
    parameter int PARITY_EN = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    serial_frame_receiver_if.slave bus
);

    localparam int CNT_W = cnt_width(DATA_W);

    rx_state_t         state_q;
    rx_state_t         state_d;
    logic [CNT_W-1:0]  count;
    logic              last;
    logic              cnt_clr;
    logic              cnt_inc;
    logic              stop_edge;
    logic              perr_d;
    logic              ferr_d;
    logic [DATA_W-1:0] data_q;
    logic              par_q;
    logic [DATA_W-1:0] pout_q;
    logic              valid_q;
    logic              perr_q;
    logic              ferr_q;

    frame_bit_counter #(.DATA_W(DATA_W)) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .bit_en (bus.bitEn),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .count  (count),
        .last   (last)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Every transition is gated by bitEn so stalled cycles freeze the frame.
    always_comb begin
        state_d   = state_q;
        cnt_clr   = 1'b1;
        cnt_inc   = 1'b0;
        stop_edge = 1'b0;
        perr_d    = (PARITY_EN != 0) && ((^data_q) ^ par_q);
        ferr_d    = (bus.sIn != LINE_IDLE);
        case (state_q)
            IDLE: begin
                if (bus.bitEn && (bus.sIn != LINE_IDLE)) state_d = DATA;
            end
            DATA: begin
                cnt_clr = last;
                cnt_inc = 1'b1;
                if (bus.bitEn && last) state_d = (PARITY_EN != 0) ? PARITY : STOP;
            end
            PARITY: begin
                if (bus.bitEn) state_d = STOP;
            end
            STOP: begin
                stop_edge = bus.bitEn;
                if (bus.bitEn) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_q <= '0;
            par_q  <= 1'b0;
        end else if (bus.bitEn) begin
            if (state_q == DATA)   data_q[count] <= bus.sIn;
            if (state_q == PARITY) par_q         <= bus.sIn;
        end
    end

    // Status flags are single-cycle pulses; pOut keeps the last word, good or bad.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pout_q  <= '0;
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (stop_edge) begin
                pout_q  <= data_q;
                perr_q  <= perr_d;
                ferr_q  <= ferr_d;
                valid_q <= ~perr_d & ~ferr_d;
            end
        end
    end

    assign bus.pOut      = pout_q;
    assign bus.valid     = valid_q;
    assign bus.parityErr = perr_q;
    assign bus.frameErr  = ferr_q;
    assign bus.busy      = (state_q != IDLE);

endmodule

// File: tb/tb_serial_frame_receiver.sv
// Directed bench for serial_frame_receiver: frame vector table plus multi-cycle corner sequences.
module tb_serial_frame_receiver;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    serial_frame_receiver_if #(.DATA_W(8)) bus ();
    serial_frame_receiver_if #(.DATA_W(8)) busNp ();

    serial_frame_receiver #(.DATA_W(8), .PARITY_EN(1)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    serial_frame_receiver #(.DATA_W(8), .PARITY_EN(0)) dutNp (
        .clk (clk),
        .rst (rst),
        .bus (busNp)
    );

    typedef struct {
        string      name;
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic [7:0] expPOut;
        logic       expValid;
        logic       expPerr;
        logic       expFerr;
    } vec_t;

    vec_t vecs[9];
    int   checks     = 0;
    int   passes     = 0;
    int   cyc        = 0;
    int   pulseCount = 0;
    int   validCyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (bus.valid) validCyc.push_back(cyc);
        if (bus.valid || bus.parityErr || bus.frameErr) pulseCount++;
    end

    task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Both receivers see the same line; inputs settle 1 time unit after each edge.
    task automatic applyStimulus(input logic b, input logic en);
        bus.sIn     = b;
        bus.bitEn   = en;
        busNp.sIn   = b;
        busNp.bitEn = en;
        @(posedge clk);
        #1;
    endtask

    task automatic sendFrame(input logic [7:0] d, input logic par, input logic stop);
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(d[i], 1'b1);
        applyStimulus(par, 1'b1);
        applyStimulus(stop, 1'b1);
    endtask

    initial begin
        logic [7:0] d;
        logic       busyAll;
        int         pc;
        int         diff;

        vecs[0] = '{"good_a5", 8'hA5, 1'b0, 1'b1, 8'hA5, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{"perr_a5", 8'hA5, 1'b1, 1'b1, 8'hA5, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{"ferr_3c", 8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b0, 1'b1};
        vecs[3] = '{"good_81", 8'h81, 1'b0, 1'b1, 8'h81, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{"good_00", 8'h00, 1'b0, 1'b1, 8'h00, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{"good_ff", 8'hFF, 1'b0, 1'b1, 8'hFF, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{"good_01", 8'h01, 1'b1, 1'b1, 8'h01, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{"perr_01", 8'h01, 1'b0, 1'b1, 8'h01, 1'b0, 1'b1, 1'b0};
        vecs[8] = '{"both_7f", 8'h7F, 1'b0, 1'b0, 8'h7F, 1'b0, 1'b1, 1'b1};

        rst         = 1'b1;
        bus.sIn     = 1'b1;
        bus.bitEn   = 1'b0;
        busNp.sIn   = 1'b1;
        busNp.bitEn = 1'b0;
        #12;
        checkOutput("rst_busy",  16'(bus.busy),      16'h0);
        checkOutput("rst_pout",  16'(bus.pOut),      16'h0);
        checkOutput("rst_valid", 16'(bus.valid),     16'h0);
        checkOutput("rst_perr",  16'(bus.parityErr), 16'h0);
        checkOutput("rst_ferr",  16'(bus.frameErr),  16'h0);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);

        for (int v = 0; v < 9; v++) begin
            sendFrame(vecs[v].data, vecs[v].par, vecs[v].stop);
            checkOutput({vecs[v].name, "_pout"},  16'(bus.pOut),      16'(vecs[v].expPOut));
            checkOutput({vecs[v].name, "_valid"}, 16'(bus.valid),     16'(vecs[v].expValid));
            checkOutput({vecs[v].name, "_perr"},  16'(bus.parityErr), 16'(vecs[v].expPerr));
            checkOutput({vecs[v].name, "_ferr"},  16'(bus.frameErr),  16'(vecs[v].expFerr));
            checkOutput({vecs[v].name, "_busy"},  16'(bus.busy),      16'h0);
            applyStimulus(1'b1, 1'b1);
            checkOutput({vecs[v].name, "_clear"},
                        16'({bus.valid, bus.parityErr, bus.frameErr}), 16'h0);
        end

        // Back-to-back frames, no idle bit in between.
        validCyc.delete();
        sendFrame(8'h00, 1'b0, 1'b1);
        checkOutput("b2b_pout0", 16'(bus.pOut), 16'h00);
        sendFrame(8'hFF, 1'b0, 1'b1);
        checkOutput("b2b_pout1", 16'(bus.pOut), 16'hFF);
        applyStimulus(1'b1, 1'b1);
        checkOutput("b2b_count", 16'(validCyc.size()), 16'd2);
        diff = (validCyc.size() >= 2) ? (validCyc[1] - validCyc[0]) : -1;
        checkOutput("b2b_spacing", 16'(diff), 16'd11);

        // bitEn on every third cycle.
        d       = 8'h5A;
        busyAll = 1'b1;
        for (int i = 0; i < 11; i++) begin
            logic b;
            b = (i == 0) ? 1'b0 : (i <= 8) ? d[i-1] : (i == 9) ? 1'b0 : 1'b1;
            applyStimulus(b, 1'b0);
            if (i > 0) busyAll &= bus.busy;
            applyStimulus(b, 1'b0);
            if (i > 0) busyAll &= bus.busy;
            applyStimulus(b, 1'b1);
        end
        checkOutput("stall_busy",  16'(busyAll),   16'h1);
        checkOutput("stall_pout",  16'(bus.pOut),  16'h5A);
        checkOutput("stall_valid", 16'(bus.valid), 16'h1);
        applyStimulus(1'b1, 1'b1);

        // Reset in the middle of the data bits.
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b1, 1'b1);
        rst = 1'b1;
        #1;
        checkOutput("midrst_pout", 16'(bus.pOut), 16'h0);
        checkOutput("midrst_busy", 16'(bus.busy), 16'h0);
        pc = pulseCount;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("midrst_nopulse", 16'(pulseCount - pc), 16'h0);
        sendFrame(8'hA5, 1'b0, 1'b1);
        checkOutput("midrst_next_pout",  16'(bus.pOut),  16'hA5);
        checkOutput("midrst_next_valid", 16'(bus.valid), 16'h1);

        // No-parity build: 10-bit frame, valid after edge 9.
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        applyStimulus(1'b1, 1'b1);
        d = 8'hC3;
        applyStimulus(1'b0, 1'b1);
        for (int i = 0; i < 8; i++) applyStimulus(d[i], 1'b1);
        checkOutput("np_pre_valid", 16'(busNp.valid), 16'h0);
        checkOutput("np_pre_busy",  16'(busNp.busy),  16'h1);
        applyStimulus(1'b1, 1'b1);
        checkOutput("np_valid", 16'(busNp.valid),     16'h1);
        checkOutput("np_pout",  16'(busNp.pOut),      16'hC3);
        checkOutput("np_perr",  16'(busNp.parityErr), 16'h0);
        applyStimulus(1'b1, 1'b1);
        checkOutput("np_clear", 16'(busNp.valid), 16'h0);
        applyStimulus(1'b1, 1'b1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
